// File: rtl/ec_scalar_mult_arbiter.sv
// Round-robin arbiter and job sequencer sharing one scalar multiplier among
// NUM_REQ clients. The winner's operands are latched, the multiplier is driven
// through a level go/done handshake, and the result returns on a shared bus
// with a one-cycle per-client strobe. An optional watchdog aborts hung jobs.
module ec_scalar_mult_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int key_size     = 256,
  parameter int integer_size = 256,
  parameter int TIMEOUT      = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*key_size-1:0]     req_m,
  input  logic [NUM_REQ*integer_size-1:0] req_px,
  input  logic [NUM_REQ*integer_size-1:0] req_py,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [integer_size-1:0]         rsp_x,
  output logic [integer_size-1:0]         rsp_y,
  output logic                            rsp_inf,
  output logic                            rsp_err,
  output logic                            busy,
  output logic                            mult_go,
  output logic [key_size-1:0]             mult_m,
  output logic [integer_size-1:0]         mult_px,
  output logic [integer_size-1:0]         mult_py,
  input  logic                            mult_done,
  input  logic                            mult_inf,
  input  logic [integer_size-1:0]         mult_x,
  input  logic [integer_size-1:0]         mult_y
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = IW + 1;
  // Timer is sized to hold TIMEOUT; one bit is kept when the watchdog is off
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           rr_ptr, rr_ptr_n;
  logic [IW-1:0]           idx, idx_n;
  logic [TW-1:0]           timer, timer_n;
  logic [NUM_REQ-1:0]      grant_n, rsp_valid_n;
  logic [integer_size-1:0] rsp_x_n, rsp_y_n;
  logic                    rsp_inf_n, rsp_err_n, mult_go_n;
  logic [key_size-1:0]     mult_m_n;
  logic [integer_size-1:0] mult_px_n, mult_py_n;

  logic                    win_found;
  logic [IW-1:0]           win_idx;
  logic [CW-1:0]           cand;
  logic [key_size-1:0]     sel_m;
  logic [integer_size-1:0] sel_px, sel_py;
  logic                    watchdog;

  assign busy = (state != IDLE);

  // Watchdog fires on the last permitted BUSY cycle; done still takes priority
  assign watchdog = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

  // Round-robin pick: first requesting client at or above rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Select the winning client's operand slices
  always_comb begin
    sel_m  = '0;
    sel_px = '0;
    sel_py = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_m  = req_m[i*key_size +: key_size];
        sel_px = req_px[i*integer_size +: integer_size];
        sel_py = req_py[i*integer_size +: integer_size];
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DRAIN sequencer
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    idx_n       = idx;
    timer_n     = timer;
    grant_n     = grant;
    rsp_valid_n = '0;
    rsp_x_n     = rsp_x;
    rsp_y_n     = rsp_y;
    rsp_inf_n   = rsp_inf;
    rsp_err_n   = rsp_err;
    mult_go_n   = mult_go;
    mult_m_n    = mult_m;
    mult_px_n   = mult_px;
    mult_py_n   = mult_py;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          idx_n     = win_idx;
          mult_m_n  = sel_m;
          mult_px_n = sel_px;
          mult_py_n = sel_py;
          grant_n   = NUM_REQ'(1) << win_idx;
          mult_go_n = 1'b1;
          timer_n   = '0;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        if (timer != '1) timer_n = timer + 1'b1;
        if (mult_done || watchdog) begin
          // An aborted job reports a zero point with the error flag set
          rsp_x_n     = mult_done ? mult_x : '0;
          rsp_y_n     = mult_done ? mult_y : '0;
          rsp_inf_n   = mult_done & mult_inf;
          rsp_err_n   = ~mult_done;
          rsp_valid_n = NUM_REQ'(1) << idx;
          grant_n     = '0;
          mult_go_n   = 1'b0;
          rr_ptr_n    = (idx == LAST) ? '0 : idx + 1'b1;
          state_n     = DRAIN;
        end
      end
      DRAIN: begin
        // Hold off new grants until the multiplier drops its stale done
        if (!mult_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any job in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      idx       <= '0;
      timer     <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      rsp_inf   <= 1'b0;
      rsp_err   <= 1'b0;
      mult_go   <= 1'b0;
      mult_m    <= '0;
      mult_px   <= '0;
      mult_py   <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      idx       <= idx_n;
      timer     <= timer_n;
      grant     <= grant_n;
      rsp_valid <= rsp_valid_n;
      rsp_x     <= rsp_x_n;
      rsp_y     <= rsp_y_n;
      rsp_inf   <= rsp_inf_n;
      rsp_err   <= rsp_err_n;
      mult_go   <= mult_go_n;
      mult_m    <= mult_m_n;
      mult_px   <= mult_px_n;
      mult_py   <= mult_py_n;
    end
  end

endmodule

// File: tb/tb_ec_scalar_mult_arbiter.sv
// Bench for ec_scalar_mult_arbiter: a behavioural multiplier with adjustable
// latency drives the handshake; expected winners, operands, results and
// timing come from a round-robin model kept in the bench.
module tb_ec_scalar_mult_arbiter;

  localparam int NR = 3;
  localparam int KS = 256;
  localparam int IS = 256;
  localparam int TO = 16;
  typedef logic [255:0] v_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*KS-1:0] req_m;
  logic [NR*IS-1:0] req_px, req_py;
  logic [NR-1:0]    grant, rsp_valid;
  logic [IS-1:0]    rsp_x, rsp_y;
  logic             rsp_inf, rsp_err, busy, mult_go;
  logic [KS-1:0]    mult_m;
  logic [IS-1:0]    mult_px, mult_py;
  logic             mult_done, mult_inf;
  logic [IS-1:0]    mult_x, mult_y;

  logic [KS-1:0] cm  [NR];
  logic [IS-1:0] cpx [NR];
  logic [IS-1:0] cpy [NR];

  int n_assert = 0;
  int n_fail   = 0;
  int exp_rr   = 0;

  int mult_delay = 10;
  int drain_lag  = 0;
  bit mult_hang  = 1'b0;
  bit inf_mode   = 1'b0;
  int cnt;
  int lag;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NR; i++) begin : g_ops
    assign req_m[i*KS +: KS]  = cm[i];
    assign req_px[i*IS +: IS] = cpx[i];
    assign req_py[i*IS +: IS] = cpy[i];
  end

  ec_scalar_mult_arbiter #(
    .NUM_REQ(NR), .key_size(KS), .integer_size(IS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_m(req_m), .req_px(req_px),
    .req_py(req_py), .grant(grant), .rsp_valid(rsp_valid), .rsp_x(rsp_x),
    .rsp_y(rsp_y), .rsp_inf(rsp_inf), .rsp_err(rsp_err), .busy(busy),
    .mult_go(mult_go), .mult_m(mult_m), .mult_px(mult_px), .mult_py(mult_py),
    .mult_done(mult_done), .mult_inf(mult_inf), .mult_x(mult_x), .mult_y(mult_y)
  );

  // Behavioural multiplier: done rises mult_delay edges after go is seen,
  // result x = px + m, y = py ^ m; done falls drain_lag edges after go drops
  always @(posedge clk) begin
    if (rst) begin
      mult_done <= 1'b0;
      mult_inf  <= 1'b0;
      mult_x    <= '0;
      mult_y    <= '0;
      cnt       <= 0;
      lag       <= 0;
    end else if (mult_go) begin
      lag <= 0;
      if (!mult_done && !mult_hang) begin
        cnt <= cnt + 1;
        if (cnt + 1 == mult_delay) begin
          mult_done <= 1'b1;
          mult_inf  <= inf_mode;
          mult_x    <= inf_mode ? '0 : mult_px + mult_m;
          mult_y    <= inf_mode ? '0 : mult_py ^ mult_m;
        end
      end
    end else begin
      cnt <= 0;
      if (mult_done) begin
        if (lag >= drain_lag) begin
          mult_done <= 1'b0;
          lag       <= 0;
        end else begin
          lag <= lag + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic v_t rnd();
    v_t v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic new_ops();
    for (int i = 0; i < NR; i++) begin
      cm[i]  = rnd();
      cpx[i] = rnd();
      cpy[i] = rnd();
    end
  endtask

  // Reference arbitration rule: first set bit scanning up from rr, wrapping
  function automatic int winner(input logic [NR-1:0] r, input int rr);
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (rr + k) % NR;
      if (((r >> c) & NR'(1)) != '0) return c;
    end
    return 0;
  endfunction

  task automatic run_job(input logic [NR-1:0] r, input bit chk_lat,
                         input int drop_after, input bit exp_err,
                         input int exp_len);
    int w, win, len;
    logic [NR-1:0] g1;
    v_t ex, ey;
    bit einf;
    win = winner(r, exp_rr);
    g1  = NR'(1) << win;
    req = r;
    w   = 0;
    do begin
      @(negedge clk);
      w++;
    end while (grant == '0 && w < 100);
    if (chk_lat) chk("grant_latency", v_t'(w), v_t'(1));
    chk("grant", v_t'(grant), v_t'(g1));
    chk("mult_go", v_t'(mult_go), v_t'(1));
    chk("mult_m", mult_m, cm[win]);
    chk("mult_px", mult_px, cpx[win]);
    chk("mult_py", mult_py, cpy[win]);
    len = 0;
    while (rsp_valid == '0 && len < 200) begin
      len++;
      if (len == drop_after) req = '0;
      @(negedge clk);
    end
    if (exp_err) begin
      ex = '0; ey = '0; einf = 1'b0;
    end else if (inf_mode) begin
      ex = '0; ey = '0; einf = 1'b1;
    end else begin
      ex = cpx[win] + cm[win]; ey = cpy[win] ^ cm[win]; einf = 1'b0;
    end
    chk("rsp_valid", v_t'(rsp_valid), v_t'(g1));
    chk("rsp_x", rsp_x, ex);
    chk("rsp_y", rsp_y, ey);
    chk("rsp_inf", v_t'(rsp_inf), v_t'(einf));
    chk("rsp_err", v_t'(rsp_err), v_t'(exp_err));
    chk("grant_drop", v_t'(grant), '0);
    chk("go_drop", v_t'(mult_go), '0);
    if (exp_len > 0) chk("busy_len", v_t'(len), v_t'(exp_len));
    exp_rr = (win + 1) % NR;
    @(negedge clk);
    chk("rsp_pulse", v_t'(rsp_valid), '0);
    chk("gap", v_t'(grant), '0);
    chk("rsp_hold", rsp_x, ex);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle", v_t'(busy), '0);
  endtask

  initial begin
    int  k, d;
    bit  seen;
    logic [NR-1:0] r;

    // Reset state
    rst = 1'b1;
    req = '0;
    new_ops();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_grant", v_t'(grant), '0);
    chk("rst_rsp_valid", v_t'(rsp_valid), '0);
    chk("rst_go", v_t'(mult_go), '0);
    chk("rst_busy", v_t'(busy), '0);
    chk("rst_mult_m", mult_m, '0);
    chk("rst_mult_px", mult_px, '0);
    chk("rst_rsp_x", rsp_x, '0);
    chk("rst_rsp_err", v_t'(rsp_err), '0);
    chk("rst_rsp_inf", v_t'(rsp_inf), '0);

    // Single job, client 0, m = 5, done after 10 cycles
    new_ops();
    cm[0] = 256'd5;
    mult_delay = 10;
    run_job(3'b001, 1'b1, 1, 1'b0, 11);
    wait_idle();

    // All clients holding request: rotating grants
    req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      new_ops();
      d = $urandom_range(2, 8);
      mult_delay = d;
      drain_lag = $urandom_range(0, 2);
      run_job(3'b111, 1'b0, -1, 1'b0, d + 1);
    end
    req = '0;
    drain_lag = 0;
    wait_idle();

    // Wrap: after client 0 finishes rr_ptr = 1, so 101 picks client 2
    new_ops();
    mult_delay = 5;
    run_job(3'b001, 1'b1, 1, 1'b0, 6);
    run_job(3'b101, 1'b0, 1, 1'b0, 6);
    wait_idle();

    // Watchdog: multiplier never completes
    new_ops();
    mult_hang = 1'b1;
    run_job(3'b010, 1'b1, 1, 1'b1, TO);
    mult_hang = 1'b0;
    wait_idle();

    // Done on the same cycle as the timeout: done wins
    new_ops();
    mult_delay = TO - 1;
    run_job(3'b100, 1'b1, 1, 1'b0, TO);
    wait_idle();

    // Client 1 drops its request two cycles after the grant
    new_ops();
    mult_delay = 6;
    run_job(3'b010, 1'b1, 3, 1'b0, 7);
    wait_idle();

    // Reset in the middle of a job
    new_ops();
    mult_delay = 10;
    req = 3'b001;
    @(negedge clk);
    chk("pre_rst_grant", v_t'(grant), v_t'(3'b001));
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_go", v_t'(mult_go), '0);
    chk("mid_rst_grant", v_t'(grant), '0);
    chk("mid_rst_busy", v_t'(busy), '0);
    chk("mid_rst_rsp_valid", v_t'(rsp_valid), '0);
    chk("mid_rst_rsp_x", rsp_x, '0);
    chk("mid_rst_mult_m", mult_m, '0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("no_rsp_after_rst", v_t'(seen), '0);
    exp_rr = 0;

    // Point at infinity result
    new_ops();
    k = $urandom_range(0, NR - 1);
    cpx[k] = '0;
    inf_mode = 1'b1;
    mult_delay = 4;
    run_job(NR'(1) << k, 1'b1, 1, 1'b0, 5);
    inf_mode = 1'b0;
    wait_idle();

    // Randomized request patterns, latencies, drain lags and drops
    for (int j = 0; j < 12; j++) begin
      new_ops();
      r = NR'($urandom_range(1, 7));
      d = $urandom_range(1, 12);
      mult_delay = d;
      drain_lag = $urandom_range(0, 3);
      run_job(r, 1'b0, ($urandom_range(0, 1) != 0) ? 1 : -1, 1'b0, d + 1);
    end
    req = '0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
